// File: rtl/cv32e41s_rpm_responder.sv
// Dual-bank RPM responder: trie-entry store for the PMP/PMR segment walker.
// Optional even-parity protection with CV32E41S_RPM_PARITY_EN.
module cv32e41s_rpm_responder #(
    parameter int DEPTH      = 2048,
    parameter int CFG_BYPASS = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        imp_req_i,
    input  logic [31:0] imp_addr_i,
    output logic        imp_rvalid_o,
    output logic [31:0] imp_rdata_b0_o,
    output logic [31:0] imp_rdata_b1_o,
    input  logic        walker_busy_i,
    input  logic        cfg_req_i,
    output logic        cfg_gnt_o,
    input  logic        cfg_we_i,
    input  logic        cfg_bank_i,
    input  logic [31:0] cfg_addr_i,
    input  logic [31:0] cfg_wdata_i,
    output logic        cfg_rvalid_o,
    output logic [31:0] cfg_rdata_o,
    output logic        init_done_o,
    output logic        parity_err_o
);

    localparam int IW = $clog2(DEPTH);
`ifdef CV32E41S_RPM_PARITY_EN
    localparam int MW = 33;
`else
    localparam int MW = 32;
`endif
    localparam logic [IW-1:0] LAST = IW'(DEPTH - 1);

    typedef enum logic {INIT, READY} state_t;

    state_t          state;
    logic [IW-1:0]   cnt;
    logic [MW-1:0]   b0_mem [DEPTH];
    logic [MW-1:0]   b1_mem [DEPTH];

    logic [IW-1:0]   w_idx;
    logic [IW-1:0]   c_idx;
    logic            w_oor;
    logic            c_oor;
    logic            ready;
    logic            w_acc;
    logic            cfg_wr;
    logic            cfg_rd;
    logic            byp0;
    logic            byp1;
    logic [MW-1:0]   wword;
    logic [MW-1:0]   word0;
    logic [MW-1:0]   word1;
    logic [MW-1:0]   c_word;
    logic            w_perr;
    logic            c_perr;
    logic [31:0]     rd0;
    logic [31:0]     rd1;
    logic            unused_bits;

    assign w_idx = imp_addr_i[IW+1:2];
    assign c_idx = cfg_addr_i[IW+1:2];
    assign w_oor = |imp_addr_i[31:IW+2];
    assign c_oor = |cfg_addr_i[31:IW+2];
    assign unused_bits = ^{imp_addr_i[1:0], cfg_addr_i[1:0]};

    assign ready     = (state == READY);
    assign cfg_gnt_o = rst_n & cfg_req_i & ready & ~walker_busy_i;
    assign cfg_wr    = cfg_gnt_o & cfg_we_i & ~c_oor;
    assign cfg_rd    = cfg_gnt_o & ~cfg_we_i;
    assign w_acc     = ready & imp_req_i;

`ifdef CV32E41S_RPM_PARITY_EN
    assign wword = {^cfg_wdata_i, cfg_wdata_i};
`else
    assign wword = cfg_wdata_i;
`endif

    // A write landing on the entry the walker reads this edge may be forwarded.
    assign byp0 = (CFG_BYPASS != 0) && cfg_wr && !cfg_bank_i && (c_idx == w_idx);
    assign byp1 = (CFG_BYPASS != 0) && cfg_wr && cfg_bank_i && (c_idx == w_idx);

    assign word0  = byp0 ? wword : b0_mem[w_idx];
    assign word1  = byp1 ? wword : b1_mem[w_idx];
    assign c_word = cfg_bank_i ? b1_mem[c_idx] : b0_mem[c_idx];

`ifdef CV32E41S_RPM_PARITY_EN
    assign w_perr = (^word0) | (^word1);
    assign c_perr = ^c_word;
`else
    assign w_perr = 1'b0;
    assign c_perr = 1'b0;
`endif

    // A corrupt entry reads as invalid so the walker faults instead of trusting it.
    assign rd0 = (w_oor || w_perr) ? '0 : word0[31:0];
    assign rd1 = w_oor ? '0 : word1[31:0];

    always_ff @(posedge clk) begin
        if (rst_n && state == INIT) begin
            b0_mem[cnt] <= '0;
            b1_mem[cnt] <= '0;
        end else if (cfg_wr) begin
            if (cfg_bank_i) begin
                b1_mem[c_idx] <= wword;
            end else begin
                b0_mem[c_idx] <= wword;
            end
        end
    end

`ifdef CV32E41S_RPM_PARITY_EN
    logic perr_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perr_q <= 1'b0;
        end else begin
            perr_q <= (w_acc & ~w_oor & w_perr) | (cfg_rd & ~c_oor & c_perr);
        end
    end

    assign parity_err_o = perr_q;
`else
    assign parity_err_o = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= INIT;
            cnt            <= '0;
            init_done_o    <= 1'b0;
            imp_rvalid_o   <= 1'b0;
            imp_rdata_b0_o <= '0;
            imp_rdata_b1_o <= '0;
            cfg_rvalid_o   <= 1'b0;
            cfg_rdata_o    <= '0;
        end else begin
            case (state)
                INIT: begin
                    cnt <= cnt + IW'(1);
                    if (cnt == LAST) begin
                        state       <= READY;
                        init_done_o <= 1'b1;
                    end
                end
                READY: begin
                    state <= READY;
                end
                default: begin
                    state <= INIT;
                end
            endcase

            imp_rvalid_o <= w_acc;
            if (w_acc) begin
                imp_rdata_b0_o <= rd0;
                imp_rdata_b1_o <= rd1;
            end

            cfg_rvalid_o <= cfg_rd;
            if (cfg_rd) begin
                cfg_rdata_o <= c_oor ? '0 : c_word[31:0];
            end
        end
    end

endmodule

// File: doc/cv32e41s_rpm_responder.md
# cv32e41s_rpm_responder

Region Protection Memory (RPM) responder: the dual-bank memory that serves the implicit-access reads issued by the 64-bit PMP/PMR segment-trie walker and accepts M-mode configuration writes that populate trie entries. Each entry holds two 32-bit words: bank 0 (CTRL/CFG) and bank 1 (GUARD/ADDROFF). The block sits beside the walker inside the core. It clears itself after reset, arbitrates configuration traffic against walker lookups, and returns read data with fixed one-cycle latency.

## Interface
Parameters:
- DEPTH, 2048: entries per bank; must be a power of two; entry index = addr[$clog2(DEPTH)+1:2].
- CFG_BYPASS, 1: 1 = a walker read colliding with a same-cycle granted write returns the new data; 0 = it returns the old data.

Ports (reset rst_n, synchronous, active-low; clock clk):
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- imp_req_i  in  1  walker read request (may be held high permanently).
- imp_addr_i  in  32  walker byte address; bits [1:0] ignored.
- imp_rvalid_o  out  1  read data valid.
- imp_rdata_b0_o  out  32  bank-0 word of addressed entry.
- imp_rdata_b1_o  out  32  bank-1 word of addressed entry.
- walker_busy_i  in  1  walker mid-walk (PREFIX_PROBING); blocks config grants.
- cfg_req_i  in  1  config access request.
- cfg_gnt_o  out  1  config access granted (combinational).
- cfg_we_i  in  1  1 = write, 0 = read.
- cfg_bank_i  in  1  bank select.
- cfg_addr_i  in  32  config byte address; bits [1:0] ignored.
- cfg_wdata_i  in  32  write data.
- cfg_rvalid_o  out  1  config read data valid.
- cfg_rdata_o  out  32  config read data.
- init_done_o  out  1  clear sequence finished.
- parity_err_o  out  1  parity mismatch pulse (see Configuration).

## Operation
- FSM states: INIT and READY. Reset enters INIT with clear counter = 0.
- INIT: writes 0 to both banks at index = counter, then increments the counter. After the write to index DEPTH-1, the FSM moves to READY. In INIT, cfg_gnt_o = 0 and imp_rvalid_o = 0.
- READY: a walker read is accepted on every cycle in which imp_req_i = 1.
- Config grant: cfg_gnt_o = cfg_req_i & READY & ~walker_busy_i.
- A granted write updates only the selected bank at the addressed index.
- A granted read returns the selected bank word on cfg_rdata_o with cfg_rvalid_o one cycle later.
- Out-of-range addresses (index ≥ DEPTH, i.e. address bits above the index field non-zero):
  - Walker read returns all zeros. Valid bit 0 causes the walker to fault.
  - Config write is dropped.
  - Config read returns 0 with rvalid.
- Walker and config accesses are independent ports. A same-cycle write and walker read to the same entry and bank resolve per CFG_BYPASS.
- A config read and a walker read may proceed in the same cycle.

## Timing
- Walker read latency is 1: the address is sampled at edge N, and imp_rvalid_o and data are valid in cycle N+1 (registered outputs). The walker consumes the data combinationally in the next state.
- Output data holds until the next accepted read. If imp_req_i = 0, imp_rvalid_o = 0 and data holds.
- Config write takes effect for reads sampled at edge N+1 or later (or same-edge, per CFG_BYPASS).
- Clear duration: DEPTH cycles. init_done_o rises in cycle DEPTH after rst_n deasserts and stays high until reset.
- Reset values: imp_rvalid_o = 0, imp_rdata_b0_o = 0, imp_rdata_b1_o = 0, cfg_gnt_o = 0, cfg_rvalid_o = 0, cfg_rdata_o = 0, init_done_o = 0, parity_err_o = 0.
- Reset asserted mid-INIT or mid-access: the counter restarts at 0, pending config reads are dropped (no cfg_rvalid_o), and the clear reruns fully.
- A cfg_req_i held while walker_busy_i = 1 stays ungranted. The requester must hold its request stable until granted.

## Configuration
- Macro CV32E41S_RPM_PARITY_EN.
- Defined:
  - Each stored word carries an even-parity bit, written on clear and config writes.
  - On a walker read mismatch in either bank, imp_rdata_b0_o is forced to 0 (entry invalid → walker fault) and parity_err_o pulses for one cycle together with imp_rvalid_o.
  - On a config read mismatch, cfg_rdata_o returns the raw word and parity_err_o pulses.
- Undefined: no parity storage, and parity_err_o is tied 0.

## Test plan
- Reset, then count cycles → init_done_o rises after exactly 2048 cycles. A walker read of addr 0x0 then returns b0 = 0, b1 = 0, rvalid = 1 the next cycle.
- Config write bank 0, addr 0x4 = 0x0004_0003, then bank 1 = 0xDEAD_BEEF. Walker read of 0x4 → b0 = 0x0004_0003, b1 = 0xDEAD_BEEF one cycle later; an adjacent entry at 0x8 still reads 0.
- walker_busy_i = 1 with cfg_req_i = 1 → cfg_gnt_o = 0 for the whole busy period. Grant is asserted in the first cycle busy drops, and a read there returns the stored data one cycle later.
- Same-cycle config write and walker read to 0x10, CFG_BYPASS = 1 → new data; repeat with CFG_BYPASS = 0 → old data.
- Walker read at 0x2000 (index 2048, out of range) → b0 = 0, b1 = 0, rvalid = 1. A config write there leaves all entries unchanged.
- With CV32E41S_RPM_PARITY_EN defined, flip a stored bit through a backdoor at 0x4 → walker read returns b0 = 0 and parity_err_o = 1 for one cycle. rst_n pulsed at cycle 100 of INIT → init_done_o rises 2048 cycles after release.
